// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter.
//   BIT_WIDTH : default address/data width
//   SZ_*      : m_size / d_size transfer-size encodings
//   state_t   : arbiter FSM state encoding
package mem_bus_pkg;

  localparam int BIT_WIDTH = 32;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_IBUS = 2'b01,
    ST_DBUS = 2'b10
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// bus_watchdog: loadable down-counter used as the memory ack timeout.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val (takes priority over en)
//   en        : decrement by one per cycle, holding at zero
//   load_val  : start value
//   expired   : counter is at its terminal count (zero)
module bus_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between an instruction-fetch port
// and a data load/store port, with fetch anti-starvation and an ack timeout.
//   clk, rst                         : clock, asynchronous active-low reset
//   i_req/i_addr -> i_rdata/i_ack_n  : fetch port, ack_n is a 1-cycle low pulse
//   d_req/d_write/d_size/d_addr/d_wdata -> d_rdata/d_ack_n : data port
//   m_req/m_write/m_addr/m_size/m_wdata/m_oe, m_rdata/m_ack_n : memory bus
//   bus_err                          : 1-cycle pulse when a transfer times out
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | bus free; arbitrate between pending requesters
// ST_IBUS | fetch transfer on the bus, waiting for m_ack_n or timeout
// ST_DBUS | data transfer on the bus, waiting for m_ack_n or timeout
import mem_bus_pkg::*;

module mem_bus_arbiter #(
  parameter int BIT_WIDTH    = mem_bus_pkg::BIT_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack_n,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack_n,
  output logic                 m_req,
  output logic                 m_write,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_wdata,
  output logic                 m_oe,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n,
  output logic                 bus_err
);

  // The watchdog is loaded with TIMEOUT-1 at grant, so the transfer aborts
  // at the end of its TIMEOUT-th cycle on the bus.
  localparam int             WD_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]     STARVE_MAX = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       grant_d;
  logic       grant_i;
  logic       wd_expired;
  logic       done;

  // No grant is made while either ack pulse is out: this gives the mandatory
  // idle cycle after every completion and keeps a still-held d_req eligible
  // on the following cycle, which is what lets the starvation limit matter.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if ((state == ST_IDLE) && i_ack_n && d_ack_n) begin
      if (d_req && !(i_req && (starve_cnt == STARVE_MAX))) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  assign done = !m_ack_n || wd_expired;

  bus_watchdog #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_d || grant_i),
    .en       (state != ST_IDLE),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_write    <= 1'b0;
      m_oe       <= 1'b0;
      m_addr     <= '0;
      m_size     <= SZ_WORD;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack_n    <= 1'b1;
      d_ack_n    <= 1'b1;
      bus_err    <= 1'b0;
    end else begin
      i_ack_n <= 1'b1;
      d_ack_n <= 1'b1;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_req) begin
            starve_cnt <= '0;
          end
          if (grant_d) begin
            state   <= ST_DBUS;
            m_req   <= 1'b1;
            m_write <= d_write;
            m_oe    <= d_write;
            m_addr  <= d_addr;
            m_size  <= d_size;
            m_wdata <= d_wdata;
            if (i_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end else if (grant_i) begin
            state      <= ST_IBUS;
            m_req      <= 1'b1;
            m_write    <= 1'b0;
            m_oe       <= 1'b0;
            m_addr     <= i_addr;
            m_size     <= SZ_WORD;
            m_wdata    <= '0;
            starve_cnt <= '0;
          end
        end
        ST_IBUS: begin
          if (done) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            m_write <= 1'b0;
            m_oe    <= 1'b0;
            i_ack_n <= 1'b0;
            if (!m_ack_n) begin
              i_rdata <= m_rdata;
            end else begin
              i_rdata <= '0;
              bus_err <= 1'b1;
            end
          end
        end
        ST_DBUS: begin
          if (done) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            m_write <= 1'b0;
            m_oe    <= 1'b0;
            d_ack_n <= 1'b0;
            if (!m_ack_n) begin
              if (!m_write) begin
                d_rdata <= m_rdata;
              end
            end else begin
              d_rdata <= '0;
              bus_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_req   <= 1'b0;
          m_write <= 1'b0;
          m_oe    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack_n;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack_n;
  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_oe;
  logic [31:0] m_rdata;
  logic        m_ack_n;
  logic        bus_err;

  mem_bus_arbiter #(
    .BIT_WIDTH    (32),
    .STARVE_LIMIT (4),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack_n (i_ack_n),
    .d_req   (d_req),
    .d_write (d_write),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack_n (d_ack_n),
    .m_req   (m_req),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_size  (m_size),
    .m_wdata (m_wdata),
    .m_oe    (m_oe),
    .m_rdata (m_rdata),
    .m_ack_n (m_ack_n),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: ack after 'delay' extra cycles; 1: never ack, expect timeout;
  // 2: never ack, transfer is killed by reset
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          mode;
  } bus_exp_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];

  int   vectors    = 0;
  int   miscompares = 0;
  logic prev_i_ack = 1'b1;
  logic prev_d_ack = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic [1:0] size, input logic write,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int delay, input int mode);
    bus_exp_t e;
    e.addr = addr; e.size = size; e.write = write; e.wdata = wdata;
    e.rdata = rdata; e.delay = delay; e.mode = mode;
    bus_q.push_back(e);
  endtask

  task automatic exp_ack(input logic is_d, input logic [31:0] rdata, input logic err);
    ack_exp_t a;
    a.is_d = is_d; a.rdata = rdata; a.err = err;
    ack_q.push_back(a);
  endtask

  task automatic wait_ack(input logic is_d, input string name);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      seen = is_d ? !d_ack_n : !i_ack_n;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // Memory model: checks each bus transfer against the expected queue and
  // answers it as that entry dictates.
  initial begin
    bus_exp_t e;
    m_ack_n = 1'b1;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && m_req) begin
        if (bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected bus request: addr %h", m_addr);
          for (int k = 0; k < 400 && m_req; k++) @(negedge clk);
        end else begin
          e = bus_q.pop_front();
          check("m_addr", m_addr, e.addr);
          check("m_size", {30'd0, m_size}, {30'd0, e.size});
          check("m_write/m_oe", {30'd0, m_write, m_oe}, {30'd0, e.write, e.write});
          if (e.write) check("m_wdata", m_wdata, e.wdata);
          if (e.mode == 0) begin
            logic ok = 1'b1;
            for (int k = 0; k < e.delay; k++) begin
              @(negedge clk);
              ok &= m_req && (m_addr == e.addr) && (m_write == e.write) &&
                    (m_oe == e.write) && (!e.write || (m_wdata == e.wdata));
            end
            if (e.delay > 0) check("bus held until ack", {31'd0, ok}, 32'd1);
            m_ack_n = 1'b0;
            m_rdata = e.rdata;
            @(negedge clk);
            m_ack_n = 1'b1;
            m_rdata = 32'h5A5A_5A5A;
            check("m_req drops after ack", {29'd0, m_req, m_write, m_oe}, 32'd0);
          end else if (e.mode == 1) begin
            int cyc = 1;
            while (m_req && cyc < 400) begin
              @(negedge clk);
              if (m_req) cyc++;
            end
            check("cycles before timeout", cyc, TIMEOUT);
          end else begin
            for (int k = 0; k < 400 && m_req; k++) @(negedge clk);
          end
        end
      end
    end
  end

  // Requester-side monitor: every ack pulse is matched against the queue.
  initial begin
    ack_exp_t a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_i_ack = 1'b1;
        prev_d_ack = 1'b1;
      end else begin
        if (!i_ack_n || !d_ack_n) begin
          check("ack pulse width", {30'd0, prev_i_ack, prev_d_ack}, {30'd0, i_ack_n | prev_i_ack, d_ack_n | prev_d_ack});
          if (ack_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected ack: i_ack_n %b d_ack_n %b", i_ack_n, d_ack_n);
          end else begin
            a = ack_q.pop_front();
            check("ack port", {30'd0, i_ack_n, d_ack_n}, a.is_d ? 32'd2 : 32'd1);
            check(a.is_d ? "d_rdata" : "i_rdata", a.is_d ? d_rdata : i_rdata, a.rdata);
            check("bus_err", {31'd0, bus_err}, {31'd0, a.err});
          end
        end
        prev_i_ack = i_ack_n;
        prev_d_ack = d_ack_n;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global time limit: tb still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    rst     = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_write = 1'b0;
    d_size  = SZ_WORD;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset ctrl", {26'd0, m_req, m_write, m_oe, bus_err, i_ack_n, d_ack_n}, 32'b000011);
    check("reset m_addr", m_addr, 32'h0);
    check("reset m_wdata/m_size", m_wdata | {30'd0, m_size}, 32'h0);
    check("reset rdata", i_rdata | d_rdata, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Plain fetch.
    exp_bus(32'h0000_0010, SZ_WORD, 1'b0, 32'h0, 32'h1234_5678, 1, 0);
    exp_ack(1'b0, 32'h1234_5678, 1'b0);
    i_addr = 32'h0000_0010;
    i_req  = 1'b1;
    wait_ack(1'b0, "fetch ack");
    i_req = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous requests: data first, fetch afterwards.
    exp_bus(32'h0800_0004, SZ_HALF, 1'b0, 32'h0, 32'hCAFE_0001, 0, 0);
    exp_bus(32'h0000_0020, SZ_WORD, 1'b0, 32'h0, 32'h0000_ABCD, 0, 0);
    exp_ack(1'b1, 32'hCAFE_0001, 1'b0);
    exp_ack(1'b0, 32'h0000_ABCD, 1'b0);
    i_addr  = 32'h0000_0020;
    d_addr  = 32'h0800_0004;
    d_size  = SZ_HALF;
    d_write = 1'b0;
    i_req   = 1'b1;
    d_req   = 1'b1;
    wait_ack(1'b1, "load ack");
    d_req = 1'b0;
    wait_ack(1'b0, "second fetch ack");
    i_req = 1'b0;
    repeat (3) @(negedge clk);

    // Store: d_rdata keeps the previous load value.
    exp_bus(32'h0800_0000, SZ_WORD, 1'b1, 32'hDEAD_BEEF, 32'h5555_5555, 3, 0);
    exp_ack(1'b1, 32'hCAFE_0001, 1'b0);
    d_addr  = 32'h0800_0000;
    d_size  = SZ_WORD;
    d_write = 1'b1;
    d_wdata = 32'hDEAD_BEEF;
    d_req   = 1'b1;
    wait_ack(1'b1, "store ack");
    d_req   = 1'b0;
    d_write = 1'b0;
    check("i_rdata held", i_rdata, 32'h0000_ABCD);
    repeat (3) @(negedge clk);

    // Starvation: four data grants, then the fetch gets the bus.
    for (int k = 1; k <= 4; k++) begin
      exp_bus(32'h0800_0100, SZ_WORD, 1'b0, 32'h0, 32'hD000_0000 + 32'(k), 0, 0);
      exp_ack(1'b1, 32'hD000_0000 + 32'(k), 1'b0);
    end
    exp_bus(32'h0000_0030, SZ_WORD, 1'b0, 32'h0, 32'h1111_2222, 0, 0);
    exp_ack(1'b0, 32'h1111_2222, 1'b0);
    d_addr = 32'h0800_0100;
    i_addr = 32'h0000_0030;
    i_req  = 1'b1;
    d_req  = 1'b1;
    wait_ack(1'b0, "starved fetch ack");
    i_req = 1'b0;
    d_req = 1'b0;
    check("starve_cnt cleared", {29'd0, dut.starve_cnt}, 32'd0);
    repeat (3) @(negedge clk);

    // Timeout on a fetch.
    exp_bus(32'h0000_0040, SZ_WORD, 1'b0, 32'h0, 32'h0, 0, 1);
    exp_ack(1'b0, 32'h0, 1'b1);
    i_addr = 32'h0000_0040;
    i_req  = 1'b1;
    wait_ack(1'b0, "timeout ack");
    i_req = 1'b0;
    @(negedge clk);
    check("bus_err one cycle", {30'd0, bus_err, m_req}, 32'd0);
    check("i_rdata after abort", i_rdata, 32'h0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a store.
    exp_bus(32'h0800_0200, SZ_BYTE, 1'b1, 32'h0000_00A5, 32'h0, 0, 2);
    d_addr  = 32'h0800_0200;
    d_size  = SZ_BYTE;
    d_write = 1'b1;
    d_wdata = 32'h0000_00A5;
    d_req   = 1'b1;
    begin
      int n = 0;
      while (!m_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("store reached bus", {31'd0, m_req}, 32'd1);
    end
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    d_req = 1'b0;
    #1;
    check("async reset ctrl", {26'd0, m_req, m_write, m_oe, bus_err, i_ack_n, d_ack_n}, 32'b000011);
    check("async reset m_addr", m_addr, 32'h0);
    check("async reset m_wdata/m_size", m_wdata | {30'd0, m_size}, 32'h0);
    check("async reset rdata", i_rdata | d_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    check("bus queue drained", bus_q.size(), 32'd0);
    check("ack queue drained", ack_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
